fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem address and IF/ID pipeline register.
// Optional FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] imem_adr,
  input  logic [31:0] imem_instr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic            id_valid_q, id_valid_d;
  logic            capture;

  // Target low bits are dropped: instructions are always word aligned.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^pc_target[1:0];

  assign pc_plus4 = pc_q + XLEN'(4);
  assign imem_adr = pc_q;
  assign capture  = !flush && !stall;

  // PC next state: redirect beats stall.
  always_comb begin
    pc_d = pc_q;
    if (pc_src) begin
      pc_d = {pc_target[XLEN-1:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  // IF/ID next state: flush beats stall.
  always_comb begin
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    if (flush) begin
      id_instr_d    = NOP_INSTR;
      id_pc_d       = '0;
      id_pc_plus4_d = '0;
      id_valid_d    = 1'b0;
    end else if (capture) begin
      id_instr_d    = imem_instr;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_plus4;
      id_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_valid_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
    end
  end

  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; a stall without flush leaves both unchanged.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (capture && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + XLEN'(1);
    end
    if (flush && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table plus stall sequence, checked through an expectation queue.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, pc_src;
  logic [31:0] pc_target;
  logic [31:0] imem_adr, imem_instr;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .imem_adr    (imem_adr),
    .imem_instr  (imem_instr),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  // Instruction memory: a distinct word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0]};
  endfunction
  assign imem_instr = mem_word(imem_adr);

  typedef struct {
    logic        rst, stall, flush, pc_src;
    logic [31:0] tgt;
    logic [31:0] adr, instr, pc, pc4;
    logic        valid;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] adr, instr, pc, pc4;
    logic        valid;
    logic [31:0] fc, bc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] fc_m = 0, bc_m = 0;

  function automatic vec_t cap(input logic r, s, f, p, input logic [31:0] t,
                               input logic [31:0] adr, input logic [31:0] ipc);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.pc_src = p; v.tgt = t;
    v.adr = adr; v.instr = mem_word(ipc); v.pc = ipc; v.pc4 = ipc + 32'd4; v.valid = 1'b1;
    return v;
  endfunction

  function automatic vec_t bub(input logic r, s, f, p, input logic [31:0] t,
                               input logic [31:0] adr);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.pc_src = p; v.tgt = t;
    v.adr = adr; v.instr = NOP; v.pc = 32'd0; v.pc4 = 32'd0; v.valid = 1'b0;
    return v;
  endfunction

  task automatic check32(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s step %0d: got %h required %h", name, idx, act, req);
  endtask

  // Drive one cycle on the falling edge, then compare just after the rising edge.
  task automatic step(input int idx, input vec_t v);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst = v.rst; stall = v.stall; flush = v.flush; pc_src = v.pc_src; pc_target = v.tgt;
    if (v.rst) begin
      fc_m = 0; bc_m = 0;
    end else begin
      if (v.flush && bc_m != 32'hFFFF_FFFF) bc_m++;
      if (!v.flush && !v.stall && fc_m != 32'hFFFF_FFFF) fc_m++;
    end
    e.idx = idx; e.adr = v.adr; e.instr = v.instr; e.pc = v.pc; e.pc4 = v.pc4;
    e.valid = v.valid; e.fc = fc_m; e.bc = bc_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard step %0d: got empty queue required one entry", idx);
    end else begin
      g = sb.pop_front();
      check32("imem_adr", g.idx, imem_adr, g.adr);
      check32("id_instr", g.idx, id_instr, g.instr);
      check32("id_pc", g.idx, id_pc, g.pc);
      check32("id_pc_plus4", g.idx, id_pc_plus4, g.pc4);
      check32("id_valid", g.idx, 32'(id_valid), 32'(g.valid));
`ifdef FETCH_PERF_CNT_EN
      check32("fetch_count", g.idx, fetch_count, g.fc);
      check32("bubble_count", g.idx, bubble_count, g.bc);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_stall;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 1'b0; pc_target = '0;

    // Reset, free run 0,4,8, three-cycle stall at PC=8, resume
    vecs.push_back(bub(1, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h4, 32'h0));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h8, 32'h4));
    vecs.push_back(cap(0, 1, 0, 0, 32'h0, 32'h8, 32'h4));
    vecs.push_back(cap(0, 1, 0, 0, 32'h0, 32'h8, 32'h4));
    vecs.push_back(cap(0, 1, 0, 0, 32'h0, 32'h8, 32'h4));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'hC, 32'h8));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h10, 32'hC));
    // Redirect with misaligned target at PC=0x10
    vecs.push_back(bub(0, 0, 1, 1, 32'h42, 32'h40));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h44, 32'h40));
    // Redirect beats stall
    vecs.push_back(bub(0, 1, 1, 1, 32'h100, 32'h100));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h104, 32'h100));
    // Flush alone: PC advances, IF/ID bubbles
    vecs.push_back(bub(0, 0, 1, 0, 32'h0, 32'h108));
    // pc_src alone: PC redirects, current word still captured
    vecs.push_back(cap(0, 0, 0, 1, 32'h203, 32'h200, 32'h108));
    // PC wrap at top of address space
    vecs.push_back(bub(0, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h4, 32'h0));
    // Reach PC=0x20, stall, then reset during the stall
    vecs.push_back(cap(0, 0, 0, 1, 32'h20, 32'h20, 32'h4));
    vecs.push_back(cap(0, 1, 0, 0, 32'h0, 32'h20, 32'h4));
    vecs.push_back(bub(1, 1, 0, 0, 32'h0, 32'h0));
    // Five free-run cycles after reset
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h4, 32'h0));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h8, 32'h4));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'hC, 32'h8));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h10, 32'hC));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h14, 32'h10));
    // Reset overrides a simultaneous redirect
    vecs.push_back(bub(1, 0, 1, 1, 32'h80, 32'h0));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h4, 32'h0));
    // Stall with flush but no redirect: PC holds, IF/ID bubbles
    vecs.push_back(bub(0, 1, 1, 0, 32'h0, 32'h4));
    vecs.push_back(cap(0, 0, 0, 0, 32'h0, 32'h8, 32'h4));

    foreach (vecs[i]) step(i, vecs[i]);

    // Stall of random length at PC=8, then resume with no gap or duplicate
    n_stall = int'($urandom_range(2, 6));
    for (int k = 0; k < n_stall; k++) step(100 + k, cap(0, 1, 0, 0, 32'h0, 32'h8, 32'h4));
    step(200, cap(0, 0, 0, 0, 32'h0, 32'hC, 32'h8));
    step(201, cap(0, 0, 0, 0, 32'h0, 32'h10, 32'hC));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
